// File: rtl/memory_dump_tx.sv
// memory_dump_tx: reads a block of 32-bit words from a synchronous memory port
// and streams each word MSB-byte first over an 8N1 UART line.
module memory_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] baseAddress,
  input  logic [15:0] wordCount,
  output logic [31:0] Address,
  output logic        memRead,
  input  logic [31:0] DataOut,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CountWidth = 16;
  localparam int unsigned WordWidth  = 32;
  localparam logic [CountWidth-1:0] LastTick = CountWidth'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    START,
    DATA,
    STOP,
    FINISH
  } stateType;

  stateType              state;
  stateType              nextState;
  logic [CountWidth-1:0] bitCount;
  logic [CountWidth-1:0] remaining;
  logic [2:0]            bitIndex;
  logic [1:0]            byteIndex;
  logic [WordWidth-1:0]  wordReg;
  logic [7:0]            currentByte;
  logic                  bitDone;
  logic                  txNext;
  logic                  accept;

  assign bitDone = (bitCount == LastTick);
  assign accept  = (state == IDLE) && start;

  // Select the byte currently on the wire, most significant byte first
  always_comb begin
    currentByte = wordReg[31:24];
    case (byteIndex)
      2'd1:    currentByte = wordReg[23:16];
      2'd2:    currentByte = wordReg[15:8];
      2'd3:    currentByte = wordReg[7:0];
      default: currentByte = wordReg[31:24];
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and next serial-line value
  always_comb begin
    nextState = state;
    txNext    = 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = (wordCount == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        nextState = CAPTURE;
      end
      CAPTURE: begin
        nextState = START;
        txNext    = 1'b0;
      end
      START: begin
        txNext = 1'b0;
        if (bitDone) begin
          nextState = DATA;
          txNext    = currentByte[0];
        end
      end
      DATA: begin
        txNext = currentByte[bitIndex];
        if (bitDone) begin
          if (bitIndex == 3'd7) begin
            nextState = STOP;
            txNext    = 1'b1;
          end else begin
            txNext = currentByte[3'(bitIndex + 3'd1)];
          end
        end
      end
      STOP: begin
        txNext = 1'b1;
        if (bitDone) begin
          if (byteIndex == 2'd3) begin
            // remaining is decremented on this same edge
            nextState = (remaining > CountWidth'(1)) ? FETCH : FINISH;
          end else begin
            nextState = START;
            txNext    = 1'b0;
          end
        end
      end
      FINISH: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Registered outputs, bit timing, byte/word sequencing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      memRead   <= 1'b0;
      Address   <= '0;
      remaining <= '0;
      bitCount  <= '0;
      bitIndex  <= '0;
      byteIndex <= '0;
      wordReg   <= '0;
    end else begin
      tx      <= txNext;
      memRead <= (nextState == FETCH);
      done    <= (nextState == FINISH);
      // An empty dump shows busy for its single FINISH cycle
      busy    <= accept || (nextState inside {FETCH, CAPTURE, START, DATA, STOP});

      // Bit-period counter reloads at every bit boundary
      if (state inside {START, DATA, STOP}) begin
        bitCount <= bitDone ? '0 : bitCount + CountWidth'(1);
      end else begin
        bitCount <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            Address   <= baseAddress;
            remaining <= wordCount;
          end
        end
        CAPTURE: begin
          wordReg   <= DataOut;
          byteIndex <= '0;
          bitIndex  <= '0;
        end
        DATA: begin
          if (bitDone) begin
            bitIndex <= bitIndex + 3'd1;
          end
        end
        STOP: begin
          if (bitDone) begin
            byteIndex <= byteIndex + 2'd1;
            if (byteIndex == 2'd3) begin
              Address   <= Address + 32'd1;
              remaining <= remaining - CountWidth'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_dump_tx.sv
// tb_memory_dump_tx: directed table-driven bench for memory_dump_tx.
module tb_memory_dump_tx;

  localparam int CPB      = 4;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int WORD_CYC = 2 + 4 * BYTE_CYC;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] baseAddress;
  logic [15:0] wordCount;
  logic [31:0] Address;
  logic        memRead;
  logic [31:0] DataOut;
  logic        tx;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  logic [7:0]  rx[$];
  logic [31:0] fetchAddrs[$];

  typedef struct {
    logic [31:0] base;
    logic [15:0] count;
    bit          spam;
    int          expCycles;
    int          expReads;
    logic [31:0] expEndAddr;
    logic [31:0] expSecondAddr;
  } vec_t;

  vec_t vecs[5];

  memory_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .baseAddress(baseAddress),
    .wordCount  (wordCount),
    .Address    (Address),
    .memRead    (memRead),
    .DataOut    (DataOut),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'hA5C3_0F81;
      32'h0000_0020: return 32'h0123_4567;
      32'h0000_0021: return 32'h89AB_CDEF;
      32'h0000_0022: return 32'hFF00_55AA;
      32'hFFFF_FFFF: return 32'hDEAD_BEEF;
      32'h0000_0000: return 32'h1357_9BDF;
      default:       return a ^ 32'h5A5A_3C3C;
    endcase
  endfunction

  // Synchronous-read memory: data valid the cycle after the strobe
  always @(posedge clock) begin
    if (memRead) DataOut <= memWord(Address);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkFirstWordBytes(input string tag);
    logic [7:0] expBytes[4];
    expBytes[0] = 8'hA5;
    expBytes[1] = 8'hC3;
    expBytes[2] = 8'h0F;
    expBytes[3] = 8'h81;
    for (int k = 0; k < 4; k++) begin
      if (rx.size() > k) check($sformatf("%s_byte%0d", tag, k), 32'(rx[k]), 32'(expBytes[k]));
      else check($sformatf("%s_byte%0d_missing", tag, k), 32'(rx.size()), 32'(k + 1));
    end
  endtask

  // Issue one start, then compare every cycle against a timing model
  task automatic runDump(input vec_t v, input string tag);
    int w, off, b, slot, phase, mism, firstBad, reads, doneCount, doneCyc;
    logic eMem, eTx, eBusy, eDone;
    logic [31:0] eAddr, word;
    logic [7:0] bt, rxByte;
    rx.delete();
    fetchAddrs.delete();
    mism = 0; firstBad = -1; reads = 0; doneCount = 0; doneCyc = -1; rxByte = '0;
    @(negedge clock);
    baseAddress = v.base;
    wordCount   = v.count;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c <= v.expCycles + 3; c++) begin
      eMem = 1'b0; eTx = 1'b1; eBusy = 1'b0; eDone = 1'b0; eAddr = '0;
      slot = -1; phase = -1;
      if (c < v.expCycles) begin
        w = c / WORD_CYC;
        off = c % WORD_CYC;
        eBusy = 1'b1;
        word = memWord(v.base + 32'(w));
        if (off == 0) begin
          eMem = 1'b1;
          eAddr = v.base + 32'(w);
        end else if (off >= 2) begin
          b     = (off - 2) / BYTE_CYC;
          slot  = ((off - 2) % BYTE_CYC) / CPB;
          phase = ((off - 2) % BYTE_CYC) % CPB;
          bt    = word[8*(3-b) +: 8];
          if (slot == 0) eTx = 1'b0;
          else if (slot == 9) eTx = 1'b1;
          else eTx = bt[slot-1];
        end
      end else if (c == v.expCycles) begin
        eDone = 1'b1;
        eBusy = (v.count == 16'd0);
      end
      if (memRead !== eMem || tx !== eTx || busy !== eBusy || done !== eDone ||
          (eMem && Address !== eAddr)) begin
        mism++;
        if (firstBad < 0) firstBad = c;
      end
      if (memRead === 1'b1) begin
        reads++;
        fetchAddrs.push_back(Address);
      end
      if (done === 1'b1) begin
        doneCount++;
        if (doneCyc < 0) doneCyc = c;
      end
      if (slot >= 1 && slot <= 8 && phase == CPB / 2) rxByte[slot-1] = tx;
      if (slot == 9 && phase == CPB / 2) rx.push_back(rxByte);
      if (v.spam && c < v.expCycles - 1) begin
        start = (c % 7 == 3);
        baseAddress = $urandom;
        wordCount = 16'($urandom_range(1, 5));
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    check($sformatf("%s_wave_mism(firstBad=%0d)", tag, firstBad), 32'(mism), 32'd0);
    check($sformatf("%s_done_count", tag), 32'(doneCount), 32'd1);
    check($sformatf("%s_done_cycle", tag), 32'(doneCyc), 32'(v.expCycles));
    check($sformatf("%s_reads", tag), 32'(reads), 32'(v.expReads));
    check($sformatf("%s_end_addr", tag), Address, v.expEndAddr);
    check($sformatf("%s_rx_bytes", tag), 32'(rx.size()), 32'(4 * v.count));
    if (v.count >= 16'd2) begin
      if (fetchAddrs.size() >= 2) check($sformatf("%s_second_fetch", tag), fetchAddrs[1], v.expSecondAddr);
      else check($sformatf("%s_second_fetch_missing", tag), 32'(fetchAddrs.size()), 32'd2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    vecs[0] = '{32'h0000_0010, 16'd1, 1'b0, 162, 1, 32'h0000_0011, 32'h0};
    vecs[1] = '{32'h0000_0020, 16'd3, 1'b0, 486, 3, 32'h0000_0023, 32'h0000_0021};
    vecs[2] = '{32'h0000_1234, 16'd0, 1'b0, 0,   0, 32'h0000_1234, 32'h0};
    vecs[3] = '{32'hFFFF_FFFF, 16'd2, 1'b0, 324, 2, 32'h0000_0001, 32'h0000_0000};
    vecs[4] = '{32'h0000_0040, 16'd2, 1'b1, 324, 2, 32'h0000_0042, 32'h0000_0041};

    reset = 1'b1;
    start = 1'b0;
    baseAddress = '0;
    wordCount = '0;
    repeat (3) @(negedge clock);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_memRead", 32'(memRead), 32'd0);
    check("reset_Address", Address, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 5; i++) begin
      runDump(vecs[i], $sformatf("v%0d", i));
      if (i == 0) checkFirstWordBytes("v0");
    end

    // Abort mid-frame: byte 1, data bit 3, then a clean restart
    @(negedge clock);
    baseAddress = 32'h10;
    wordCount = 16'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2 + BYTE_CYC + 4 * CPB + 2) @(negedge clock);
    check("abort_pre_tx", 32'(tx), 32'd0);
    check("abort_pre_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_memRead", 32'(memRead), 32'd0);
    check("abort_Address", Address, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("after_abort_idle%0d", k), {29'd0, done, busy, tx}, 32'b001);
      @(negedge clock);
    end
    runDump(vecs[0], "restart");
    checkFirstWordBytes("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
